// File: rtl/cordic_arb_pkg.sv
// cordic_arb_pkg
// Shared definitions for the CORDIC engine arbiter:
//   - state_e      : FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   - DEFAULT_*    : default operand MSB index and timeout length
//   - pick_winner  : round-robin winner selection between two requesters
package cordic_arb_pkg;

    localparam int DEFAULT_WIDTH   = 15;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // A lone requester always wins. Under contention, the requester that
    // did not win last time goes next, so neither side can starve.
    function automatic logic pick_winner(input logic v0, input logic v1, input logic last);
        logic win;
        win = 1'b0;
        if (v0 && v1) begin
            win = ~last;
        end else if (v1) begin
            win = 1'b1;
        end
        return win;
    endfunction

endpackage

// File: rtl/cordic_arbiter_mux2.sv
// cordic_arbiter_mux2
// Generic 2:1 multiplexer used for operand selection.
// Ports:
//   a_i   : input selected when sel_i = 0
//   b_i   : input selected when sel_i = 1
//   sel_i : select
//   y_o   : selected output
module cordic_arbiter_mux2 #(
    parameter int WIDTH = 15
) (
    input  logic [WIDTH:0] a_i,
    input  logic [WIDTH:0] b_i,
    input  logic           sel_i,
    output logic [WIDTH:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter
// Shares one CORDIC engine between two requesters. A round-robin arbiter in
// IDLE accepts one operand pair, the FSM pulses eng_start, waits for
// eng_done, then returns the result with a one-cycle rsp_valid strobe.
//
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   req{0,1}_valid/_x/_y, _ready      : requester handshakes and operands
//   eng_start, eng_x, eng_y           : start pulse and operands to the engine
//   eng_done, eng_result              : engine completion and result
//   rsp_valid, rsp_id, rsp_data       : response strobe, owner, result
//   busy                              : high whenever the FSM is not IDLE
//   err                               : timeout flag, pulsed with rsp_valid
//
// Optional feature: define CORDIC_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles. Without it WAIT is unbounded and err is tied low.
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [WIDTH:0] req0_x,
    input  logic [WIDTH:0] req0_y,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [WIDTH:0] req1_x,
    input  logic [WIDTH:0] req1_y,
    output logic           req1_ready,
    output logic           eng_start,
    output logic [WIDTH:0] eng_x,
    output logic [WIDTH:0] eng_y,
    input  logic           eng_done,
    input  logic [WIDTH:0] eng_result,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [WIDTH:0] rsp_data,
    output logic           busy,
    output logic           err
);

    state_e         state_q;
    logic           last_grant_q;
    logic           grant_q;
    logic           eng_start_q;
    logic [WIDTH:0] eng_x_q;
    logic [WIDTH:0] eng_y_q;
    logic           rsp_valid_q;
    logic           rsp_id_q;
    logic [WIDTH:0] rsp_data_q;

    logic           winner;
    logic           accept;
    logic           timeout_hit;
    logic [WIDTH:0] sel_x;
    logic [WIDTH:0] sel_y;

    // Arbitration is combinational so a requester sees ready in the same
    // cycle it presents valid; ready can only ever go to the single winner.
    always_comb begin
        winner     = pick_winner(req0_valid, req1_valid, last_grant_q);
        req0_ready = (state_q == IDLE) && req0_valid && !winner;
        req1_ready = (state_q == IDLE) && req1_valid && winner;
        accept     = req0_ready || req1_ready;
    end

    cordic_arbiter_mux2 #(.WIDTH(WIDTH)) u_mux_x (
        .a_i   (req0_x),
        .b_i   (req1_x),
        .sel_i (winner),
        .y_o   (sel_x)
    );

    cordic_arbiter_mux2 #(.WIDTH(WIDTH)) u_mux_y (
        .a_i   (req0_y),
        .b_i   (req1_y),
        .sel_i (winner),
        .y_o   (sel_y)
    );

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    // The count is cleared during ISSUE so it reads 0 on the first WAIT
    // cycle; the last allowed WAIT cycle is therefore the one at TIMEOUT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign err         = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Main FSM. Strobes default low every cycle and are set only on the
    // transition into the state that owns them, so each lasts one cycle.
    // eng_done takes priority over a timeout that expires on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            eng_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        eng_x_q     <= sel_x;
                        eng_y_q     <= sel_y;
                        grant_q     <= winner;
                        eng_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        rsp_data_q  <= eng_result;
                        rsp_id_q    <= grant_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        rsp_data_q  <= '0;
                        rsp_id_q    <= grant_q;
                        rsp_valid_q <= 1'b1;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        err_q       <= 1'b1;
`endif
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    last_grant_q <= grant_q;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign eng_start = eng_start_q;
    assign eng_x     = eng_x_q;
    assign eng_y     = eng_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule
